// File: rtl/pcie_ss_ib2sb_flex.sv
// In-band to side-band header converter: moves the SOP header onto tuser_vendor
// and realigns the payload to bit 0, with passthrough, malformed-drop and flush support.
module pcie_ss_ib2sb_flex #(
    parameter int DATA_WIDTH = 512,
    parameter int HDR_WIDTH  = 256,
    parameter int ERR_CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_tvalid,
    output logic                    in_tready,
    input  logic [DATA_WIDTH-1:0]   in_tdata,
    input  logic [DATA_WIDTH/8-1:0] in_tkeep,
    input  logic                    in_tlast,
    input  logic                    in_tuser_vendor,
    input  logic                    passthru,
    output logic                    out_tvalid,
    input  logic                    out_tready,
    output logic [DATA_WIDTH-1:0]   out_tdata,
    output logic [DATA_WIDTH/8-1:0] out_tkeep,
    output logic                    out_tlast,
    output logic [HDR_WIDTH:0]      out_tuser_vendor,
    output logic                    out_hvalid,
    output logic [ERR_CNT_W-1:0]    err_cnt
);

    localparam int HB = HDR_WIDTH / 8;
    localparam int DB = DATA_WIDTH / 8;
    localparam int RW = DATA_WIDTH - HDR_WIDTH;
    localparam int RB = DB - HB;

    typedef enum logic [2:0] {ST_SOP, ST_BODY, ST_FLUSH, ST_DROP, ST_PASS} state_t;

    state_t                  state_q, state_d;
    logic                    out_tvalid_q, out_tvalid_d;
    logic [DATA_WIDTH-1:0]   out_tdata_q, out_tdata_d;
    logic [DB-1:0]           out_tkeep_q, out_tkeep_d;
    logic                    out_tlast_q, out_tlast_d;
    logic [HDR_WIDTH:0]      out_tuser_q, out_tuser_d;
    logic                    out_hvalid_q, out_hvalid_d;
    logic [ERR_CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic [HDR_WIDTH-1:0]    hdr_q, hdr_d;
    logic                    vendor_q, vendor_d;
    logic [RW-1:0]           hold_q, hold_d;
    logic [RB-1:0]           hold_keep_q, hold_keep_d;
    logic                    first_q, first_d;

    logic load;
    logic accept;

    assign load      = !out_tvalid_q || out_tready;
    assign in_tready = load && (state_q != ST_FLUSH);
    assign accept    = in_tvalid && in_tready;

    always_comb begin
        state_d      = state_q;
        out_tvalid_d = out_tvalid_q;
        out_tdata_d  = out_tdata_q;
        out_tkeep_d  = out_tkeep_q;
        out_tlast_d  = out_tlast_q;
        out_tuser_d  = out_tuser_q;
        out_hvalid_d = out_hvalid_q;
        err_cnt_d    = err_cnt_q;
        hdr_d        = hdr_q;
        vendor_d     = vendor_q;
        hold_d       = hold_q;
        hold_keep_d  = hold_keep_q;
        first_d      = first_q;

        // An output slot that loads with nothing to emit becomes a bubble.
        if (load) begin
            out_tvalid_d = 1'b0;
        end

        case (state_q)
            ST_SOP: begin
                if (accept) begin
                    if (passthru) begin
                        out_tvalid_d = 1'b1;
                        out_tdata_d  = in_tdata;
                        out_tkeep_d  = in_tkeep;
                        out_tlast_d  = in_tlast;
                        out_hvalid_d = 1'b1;
                        out_tuser_d  = {in_tdata[HDR_WIDTH-1:0], in_tuser_vendor};
                        state_d      = in_tlast ? ST_SOP : ST_PASS;
                    end else if (in_tkeep[HB-1:0] != '1) begin
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                        end
                        state_d = in_tlast ? ST_SOP : ST_DROP;
                    end else if (in_tlast) begin
                        out_tvalid_d = 1'b1;
                        out_tkeep_d  = DB'(in_tkeep[DB-1:HB]);
                        out_tdata_d  = (in_tkeep[DB-1:HB] != '0) ? (in_tdata >> HDR_WIDTH) : '0;
                        out_tlast_d  = 1'b1;
                        out_hvalid_d = 1'b1;
                        out_tuser_d  = {in_tdata[HDR_WIDTH-1:0], in_tuser_vendor};
                    end else begin
                        hdr_d       = in_tdata[HDR_WIDTH-1:0];
                        vendor_d    = in_tuser_vendor;
                        hold_d      = in_tdata[DATA_WIDTH-1:HDR_WIDTH];
                        hold_keep_d = in_tkeep[DB-1:HB];
                        first_d     = 1'b1;
                        state_d     = ST_BODY;
                    end
                end
            end
            ST_BODY: begin
                if (accept) begin
                    out_tvalid_d = 1'b1;
                    out_tdata_d  = {in_tdata[HDR_WIDTH-1:0], hold_q};
                    out_tkeep_d  = {in_tkeep[HB-1:0], hold_keep_q};
                    out_hvalid_d = first_q;
                    out_tuser_d  = first_q ? {hdr_q, vendor_q} : '0;
                    out_tlast_d  = 1'b0;
                    first_d      = 1'b0;
                    hold_d       = in_tdata[DATA_WIDTH-1:HDR_WIDTH];
                    hold_keep_d  = in_tkeep[DB-1:HB];
                    if (in_tlast) begin
                        // Upper bytes left over in the last beat spill into a flush beat.
                        if (in_tkeep[DB-1:HB] != '0) begin
                            state_d = ST_FLUSH;
                        end else begin
                            out_tlast_d = 1'b1;
                            state_d     = ST_SOP;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (load) begin
                    out_tvalid_d = 1'b1;
                    out_tdata_d  = DATA_WIDTH'(hold_q);
                    out_tkeep_d  = DB'(hold_keep_q);
                    out_tlast_d  = 1'b1;
                    out_hvalid_d = 1'b0;
                    out_tuser_d  = '0;
                    state_d      = ST_SOP;
                end
            end
            ST_DROP: begin
                if (accept && in_tlast) begin
                    state_d = ST_SOP;
                end
            end
            ST_PASS: begin
                if (accept) begin
                    out_tvalid_d = 1'b1;
                    out_tdata_d  = in_tdata;
                    out_tkeep_d  = in_tkeep;
                    out_tlast_d  = in_tlast;
                    out_hvalid_d = 1'b0;
                    out_tuser_d  = '0;
                    state_d      = in_tlast ? ST_SOP : ST_PASS;
                end
            end
            default: state_d = ST_SOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_SOP;
            out_tvalid_q <= 1'b0;
            out_tdata_q  <= '0;
            out_tkeep_q  <= '0;
            out_tlast_q  <= 1'b0;
            out_tuser_q  <= '0;
            out_hvalid_q <= 1'b0;
            err_cnt_q    <= '0;
            hdr_q        <= '0;
            vendor_q     <= 1'b0;
            hold_q       <= '0;
            hold_keep_q  <= '0;
            first_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_tvalid_q <= out_tvalid_d;
            out_tdata_q  <= out_tdata_d;
            out_tkeep_q  <= out_tkeep_d;
            out_tlast_q  <= out_tlast_d;
            out_tuser_q  <= out_tuser_d;
            out_hvalid_q <= out_hvalid_d;
            err_cnt_q    <= err_cnt_d;
            hdr_q        <= hdr_d;
            vendor_q     <= vendor_d;
            hold_q       <= hold_d;
            hold_keep_q  <= hold_keep_d;
            first_q      <= first_d;
        end
    end

    assign out_tvalid       = out_tvalid_q;
    assign out_tdata        = out_tdata_q;
    assign out_tkeep        = out_tkeep_q;
    assign out_tlast        = out_tlast_q;
    assign out_tuser_vendor = out_tuser_q;
    assign out_hvalid       = out_hvalid_q;
    assign err_cnt          = err_cnt_q;

endmodule

// File: tb/tb_pcie_ss_ib2sb_flex.sv
// Directed bench for pcie_ss_ib2sb_flex (512-bit bus, 256-bit header, 4-bit error counter
// so saturation is reachable in a few packets).
module tb_pcie_ss_ib2sb_flex;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_tvalid;
    logic         in_tready;
    logic [511:0] in_tdata;
    logic [63:0]  in_tkeep;
    logic         in_tlast;
    logic         in_tuser_vendor;
    logic         passthru;
    logic         out_tvalid;
    logic         out_tready;
    logic [511:0] out_tdata;
    logic [63:0]  out_tkeep;
    logic         out_tlast;
    logic [256:0] out_tuser_vendor;
    logic         out_hvalid;
    logic [3:0]   err_cnt;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] FULL = 64'hFFFF_FFFF_FFFF_FFFF;

    logic [511:0] b0, b1, b2;

    always #5 clk = ~clk;

    pcie_ss_ib2sb_flex #(.DATA_WIDTH(512), .HDR_WIDTH(256), .ERR_CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata),
        .in_tkeep(in_tkeep), .in_tlast(in_tlast), .in_tuser_vendor(in_tuser_vendor),
        .passthru(passthru),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
        .out_tkeep(out_tkeep), .out_tlast(out_tlast), .out_tuser_vendor(out_tuser_vendor),
        .out_hvalid(out_hvalid), .err_cnt(err_cnt)
    );

    function automatic logic [511:0] mk(input logic [7:0] tag);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = {tag, 8'hC3, 8'(i), 8'h5A};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one beat and return #1 after the edge on which it was accepted.
    task automatic send(input logic [511:0] d, input logic [63:0] k, input logic l,
                        input logic v, input logic p);
        int n = 0;
        in_tvalid = 1'b1; in_tdata = d; in_tkeep = k; in_tlast = l;
        in_tuser_vendor = v; passthru = p;
        while (!in_tready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 20) chk("send_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        in_tvalid = 1'b0;
    endtask

    task automatic idle_cycle();
        in_tvalid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_tvalid = 1'b0; in_tdata = '0; in_tkeep = '0; in_tlast = 1'b0;
        in_tuser_vendor = 1'b0; passthru = 1'b0; out_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tvalid", out_tvalid, 1'b0);
        chk("rst_tlast", out_tlast, 1'b0);
        chk("rst_hvalid", out_hvalid, 1'b0);
        chk("rst_tdata", out_tdata, 512'h0);
        chk("rst_tkeep", out_tkeep, 64'h0);
        chk("rst_tuser", out_tuser_vendor, 257'h0);
        chk("rst_err", err_cnt, 4'h0);
        chk("rst_tready", in_tready, 1'b1);
        rst_n = 1'b1;
        idle_cycle();

        // Header-only packet
        b0 = mk(8'h11);
        send(b0, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
        chk("ho_tvalid", out_tvalid, 1'b1);
        chk("ho_tkeep", out_tkeep, 64'h0);
        chk("ho_tlast", out_tlast, 1'b1);
        chk("ho_hvalid", out_hvalid, 1'b1);
        chk("ho_tdata", out_tdata, 512'h0);
        chk("ho_tuser", out_tuser_vendor, {b0[255:0], 1'b1});
        idle_cycle();
        chk("ho_bubble", out_tvalid, 1'b0);

        // Single beat with 16B payload
        b0 = mk(8'h22);
        send(b0, 64'h0000_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        chk("sb_tvalid", out_tvalid, 1'b1);
        chk("sb_tkeep", out_tkeep, 64'hFFFF);
        chk("sb_tdata", out_tdata, {256'h0, b0[511:256]});
        chk("sb_tdata_lo", out_tdata[127:0], b0[383:256]);
        chk("sb_tuser", out_tuser_vendor, {b0[255:0], 1'b0});
        chk("sb_tlast", out_tlast, 1'b1);
        idle_cycle();

        // 3-beat in-band packet, last beat fits without a flush
        b0 = mk(8'h31); b1 = mk(8'h32); b2 = mk(8'h33);
        send(b0, FULL, 1'b0, 1'b1, 1'b0);
        chk("m3_b0_none", out_tvalid, 1'b0);
        send(b1, FULL, 1'b0, 1'b0, 1'b0);
        chk("m3_b1_tvalid", out_tvalid, 1'b1);
        chk("m3_b1_tdata", out_tdata, {b1[255:0], b0[511:256]});
        chk("m3_b1_tkeep", out_tkeep, FULL);
        chk("m3_b1_hvalid", out_hvalid, 1'b1);
        chk("m3_b1_tuser", out_tuser_vendor, {b0[255:0], 1'b1});
        chk("m3_b1_tlast", out_tlast, 1'b0);
        send(b2, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        chk("m3_b2_tdata", out_tdata, {b2[255:0], b1[511:256]});
        chk("m3_b2_tkeep", out_tkeep, FULL);
        chk("m3_b2_tlast", out_tlast, 1'b1);
        chk("m3_b2_hvalid", out_hvalid, 1'b0);
        chk("m3_b2_tuser", out_tuser_vendor, 257'h0);
        chk("m3_no_flush_tready", in_tready, 1'b1);
        idle_cycle();
        chk("m3_no_flush", out_tvalid, 1'b0);

        // 2-beat packet with a full second beat: needs a flush beat
        b0 = mk(8'h41); b1 = mk(8'h42);
        send(b0, FULL, 1'b0, 1'b0, 1'b0);
        send(b1, FULL, 1'b1, 1'b0, 1'b0);
        chk("fl_b1_tdata", out_tdata, {b1[255:0], b0[511:256]});
        chk("fl_b1_tlast", out_tlast, 1'b0);
        chk("fl_b1_hvalid", out_hvalid, 1'b1);
        chk("fl_tready_low", in_tready, 1'b0);
        idle_cycle();
        chk("fl_tvalid", out_tvalid, 1'b1);
        chk("fl_tdata", out_tdata, {256'h0, b1[511:256]});
        chk("fl_tkeep", out_tkeep, 64'h0000_0000_FFFF_FFFF);
        chk("fl_tlast", out_tlast, 1'b1);
        chk("fl_hvalid", out_hvalid, 1'b0);
        chk("fl_tready_back", in_tready, 1'b1);
        idle_cycle();

        // Malformed SOP on a 3-beat packet
        send(mk(8'h51), 64'hFFFF, 1'b0, 1'b0, 1'b0);
        chk("bad_b0_none", out_tvalid, 1'b0);
        send(mk(8'h52), FULL, 1'b0, 1'b0, 1'b0);
        chk("bad_b1_none", out_tvalid, 1'b0);
        send(mk(8'h53), FULL, 1'b1, 1'b0, 1'b0);
        chk("bad_b2_none", out_tvalid, 1'b0);
        chk("bad_err1", err_cnt, 4'd1);
        b0 = mk(8'h54);
        send(b0, 64'h0000_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
        chk("after_bad_tvalid", out_tvalid, 1'b1);
        chk("after_bad_tdata", out_tdata, {256'h0, b0[511:256]});
        chk("after_bad_tuser", out_tuser_vendor, {b0[255:0], 1'b1});
        idle_cycle();

        // Saturation of the error counter
        for (int i = 0; i < 14; i++) send(mk(8'h80 + 8'(i)), 64'h0, 1'b1, 1'b0, 1'b0);
        chk("sat_err15", err_cnt, 4'd15);
        send(mk(8'h9F), 64'h0, 1'b1, 1'b0, 1'b0);
        chk("sat_hold", err_cnt, 4'd15);
        chk("sat_no_out", out_tvalid, 1'b0);

        // Passthrough with a stall, passthru dropped mid-packet, then reset mid-packet
        b0 = mk(8'hA1); b1 = mk(8'hA2); b2 = mk(8'hA3);
        send(b0, FULL, 1'b0, 1'b1, 1'b1);
        chk("pt_b0_tdata", out_tdata, b0);
        chk("pt_b0_hvalid", out_hvalid, 1'b1);
        chk("pt_b0_tuser", out_tuser_vendor, {b0[255:0], 1'b1});
        out_tready = 1'b0;
        in_tvalid = 1'b1; in_tdata = b1; in_tkeep = FULL; in_tlast = 1'b0; passthru = 1'b0;
        #1;
        chk("pt_stall_tready", in_tready, 1'b0);
        @(posedge clk); #1;
        chk("pt_stall_tvalid", out_tvalid, 1'b1);
        chk("pt_stall_tdata", out_tdata, b0);
        chk("pt_stall_hvalid", out_hvalid, 1'b1);
        out_tready = 1'b1;
        send(b1, FULL, 1'b0, 1'b0, 1'b0);
        chk("pt_b1_tdata", out_tdata, b1);
        chk("pt_b1_tkeep", out_tkeep, FULL);
        chk("pt_b1_hvalid", out_hvalid, 1'b0);
        chk("pt_b1_tuser", out_tuser_vendor, 257'h0);
        send(b2, FULL, 1'b0, 1'b0, 1'b0);
        chk("pt_b2_tdata", out_tdata, b2);
        rst_n = 1'b0;
        idle_cycle();
        chk("mid_rst_tvalid", out_tvalid, 1'b0);
        chk("mid_rst_err", err_cnt, 4'd0);
        rst_n = 1'b1;
        b0 = mk(8'hB1);
        send(b0, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        chk("post_rst_tkeep", out_tkeep, 64'h0);
        chk("post_rst_hvalid", out_hvalid, 1'b1);
        chk("post_rst_tuser", out_tuser_vendor, {b0[255:0], 1'b0});
        chk("post_rst_tdata", out_tdata, 512'h0);
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
